i2c_byte_engine: RTL and testbench

I2C_BYTE_ENGINE -- requirements
Module: i2c_byte_engine

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_sync.sv | 32 +++
 rtl/i2c_byte_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2c_byte_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared types for the I2C byte engine: upstream command encoding, the
// engine state machine states, the four quarter phases of one bit-level
// action, and the width of the quarter counter.
package i2c_pkg;

  // Upstream command encoding as driven on the command port.
  typedef enum logic [1:0] {
    I2C_START    = 2'b00,
    I2C_STOP     = 2'b01,
    I2C_TRANSMIT = 2'b10,
    I2C_RECEIVE  = 2'b11
  } i2cCmd_e;

  // Engine states; BIT covers the eight data cells, ACK the ninth cell.
  typedef enum logic [2:0] {
    IDLE,
    START,
    STOP,
    BIT,
    ACK
  } i2cState_e;

  // Quarter phases of a single bit-level action.
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_e;

  // Wide enough for the largest legal CLOCK_DIV (65535).
  localparam int QCNT_W = 16;

endpackage

// File: rtl/i2c_sync.sv
// i2c_sync
// Two-flop synchronizer for one open-drain pad input. Both flops preset
// to 1 so a released (pulled-up) line reads high straight out of reset.
// Ports:
//   clk     - sole clock
//   reset   - asynchronous active-low reset
//   async_i - raw pad input
//   sync_o  - synchronized level, two clk cycles behind the pad
module i2c_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Plain two-stage shift; only the second stage is ever used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine
// Byte-level I2C master: executes one start, stop, transmit-byte or
// receive-byte command at a time, generating SCL/SDA as open-drain pull
// enables. Every bit-level action is split into four quarter phases of
// CLOCK_DIV clk cycles each; phases that release SCL honour clock stretching.
// Ports:
//   clk, reset           - clock and asynchronous active-low reset
//   command              - 00 start, 01 stop, 10 transmit, 11 receive
//   transmitData         - byte sent by a transmit
//   transmitAck          - ack bit sent after a receive (0 = ACK)
//   transmitValid        - command request, held until cycleDone
//   cycleDone            - one-clk pulse when a command is accepted
//   busy                 - command in progress
//   receiveData          - byte captured by the last completed receive
//   receiveAck           - ack bit sampled by the last completed transmit
//   sclIn, sdaIn         - pad inputs
//   sclOe, sdaOe         - 1 pulls the corresponding line low
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int CLOCK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] command,
  input  logic [7:0] transmitData,
  input  logic       transmitAck,
  input  logic       transmitValid,
  output logic       cycleDone,
  output logic       busy,
  output logic [7:0] receiveData,
  output logic       receiveAck,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sclOe,
  output logic       sdaOe
);

  localparam logic [QCNT_W-1:0] RELOAD = QCNT_W'(CLOCK_DIV - 1);

  logic sclSync;
  logic sdaSync;

  i2c_sync sclSyncInst (
    .clk    (clk),
    .reset  (reset),
    .async_i(sclIn),
    .sync_o (sclSync)
  );

  i2c_sync sdaSyncInst (
    .clk    (clk),
    .reset  (reset),
    .async_i(sdaIn),
    .sync_o (sdaSync)
  );

  i2cState_e         state_q;
  quarter_e          quarter_q;
  logic [QCNT_W-1:0] qCnt_q;
  logic [2:0]        bitCnt_q;
  i2cCmd_e           cmd_q;
  logic [7:0]        shift_q;
  logic              ackBit_q;
  logic              ackSample_q;
  logic              busy_q;
  logic              cycleDone_q;
  logic              sclOe_q;
  logic              sdaOe_q;
  logic [7:0]        receiveData_q;
  logic              receiveAck_q;

  // Phases in which SCL has been released: the quarter count is frozen
  // until the synchronized line actually reads high (slave stretching).
  logic sclReleasePhase;
  logic stretchHold;

  assign sclReleasePhase = (state_q == START && quarter_q == Q0) ||
                           (state_q == STOP  && quarter_q == Q1) ||
                           ((state_q == BIT || state_q == ACK) && quarter_q == Q1);
  assign stretchHold     = sclReleasePhase && !sclSync;

  // Single FSM. Line drive for a phase is registered on the edge that
  // enters it. A shared shift register serves both directions: it shifts
  // out the transmit byte MSB first and shifts in samples at the LSB, so
  // after eight cells it holds the received byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      quarter_q     <= Q0;
      qCnt_q        <= '0;
      bitCnt_q      <= '0;
      cmd_q         <= I2C_START;
      shift_q       <= '0;
      ackBit_q      <= 1'b1;
      ackSample_q   <= 1'b1;
      busy_q        <= 1'b0;
      cycleDone_q   <= 1'b0;
      sclOe_q       <= 1'b0;
      sdaOe_q       <= 1'b0;
      receiveData_q <= 8'h00;
      receiveAck_q  <= 1'b1;
    end else begin
      cycleDone_q <= 1'b0;
      if (state_q == IDLE) begin
        if (transmitValid) begin
          cmd_q       <= i2cCmd_e'(command);
          shift_q     <= transmitData;
          ackBit_q    <= transmitAck;
          cycleDone_q <= 1'b1;
          busy_q      <= 1'b1;
          quarter_q   <= Q0;
          qCnt_q      <= RELOAD;
          bitCnt_q    <= '0;
          case (i2cCmd_e'(command))
            // SDA is released here; SCL follows one clk later so a
            // repeated start never lets both rise on the same edge.
            I2C_START: begin
              state_q <= START;
              sdaOe_q <= 1'b0;
            end
            I2C_STOP: begin
              state_q <= STOP;
              sdaOe_q <= 1'b1;
              sclOe_q <= 1'b1;
            end
            I2C_TRANSMIT: begin
              state_q <= BIT;
              sclOe_q <= 1'b1;
              sdaOe_q <= ~transmitData[7];
            end
            default: begin
              state_q <= BIT;
              sclOe_q <= 1'b1;
              sdaOe_q <= 1'b0;
            end
          endcase
        end
      end else begin
        if (state_q == START && quarter_q == Q0) begin
          sclOe_q <= 1'b0;
        end
        if (!stretchHold) begin
          if (qCnt_q != '0) begin
            qCnt_q <= qCnt_q - QCNT_W'(1);
          end else begin
            qCnt_q <= RELOAD;
            case (state_q)
              START: begin
                case (quarter_q)
                  Q0: begin
                    quarter_q <= Q1;
                    sdaOe_q   <= 1'b1;
                  end
                  Q1: begin
                    quarter_q <= Q2;
                    sclOe_q   <= 1'b1;
                  end
                  default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    quarter_q <= Q0;
                    qCnt_q    <= '0;
                  end
                endcase
              end
              STOP: begin
                case (quarter_q)
                  Q0: begin
                    quarter_q <= Q1;
                    sclOe_q   <= 1'b0;
                  end
                  Q1: begin
                    quarter_q <= Q2;
                    sdaOe_q   <= 1'b0;
                  end
                  default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    quarter_q <= Q0;
                    qCnt_q    <= '0;
                  end
                endcase
              end
              BIT, ACK: begin
                case (quarter_q)
                  Q0: begin
                    quarter_q <= Q1;
                    sclOe_q   <= 1'b0;
                  end
                  Q1: begin
                    quarter_q <= Q2;
                  end
                  // End of Q2 is the last clk of the SCL-high window.
                  Q2: begin
                    quarter_q <= Q3;
                    sclOe_q   <= 1'b1;
                    if (state_q == BIT) begin
                      shift_q <= {shift_q[6:0], sdaSync};
                    end else begin
                      ackSample_q <= sdaSync;
                    end
                  end
                  default: begin
                    if (state_q == BIT) begin
                      // 3-bit counter wraps 7->0 as the ACK cell begins.
                      bitCnt_q  <= bitCnt_q + 3'd1;
                      quarter_q <= Q0;
                      if (bitCnt_q == 3'd7) begin
                        state_q <= ACK;
                        sdaOe_q <= (cmd_q == I2C_RECEIVE) ? ~ackBit_q : 1'b0;
                      end else begin
                        sdaOe_q <= (cmd_q == I2C_TRANSMIT) ? ~shift_q[7] : 1'b0;
                      end
                    end else begin
                      // Byte complete: SCL stays pulled low, SDA released.
                      state_q   <= IDLE;
                      busy_q    <= 1'b0;
                      quarter_q <= Q0;
                      qCnt_q    <= '0;
                      sdaOe_q   <= 1'b0;
                      if (cmd_q == I2C_TRANSMIT) begin
                        receiveAck_q <= ackSample_q;
                      end else begin
                        receiveData_q <= shift_q;
                      end
                    end
                  end
                endcase
              end
              default: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

  assign cycleDone   = cycleDone_q;
  assign busy        = busy_q;
  assign receiveData = receiveData_q;
  assign receiveAck  = receiveAck_q;
  assign sclOe       = sclOe_q;
  assign sdaOe       = sdaOe_q;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb_i2c_byte_engine
// Directed bench for i2c_byte_engine with CLOCK_DIV=4 on a pulled-up
// open-drain bus, with a simple slave that acks, sends bytes and stretches.
module tb_i2c_byte_engine;

  localparam int CLOCK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] command = 2'b00;
  logic [7:0] transmitData = 8'h00;
  logic       transmitAck = 1'b1;
  logic       transmitValid = 1'b0;
  logic       cycleDone;
  logic       busy;
  logic [7:0] receiveData;
  logic       receiveAck;
  logic       sclOe;
  logic       sdaOe;
  logic       slaveSclLow = 1'b0;
  logic       slaveSdaLow = 1'b0;

  // Open-drain bus with pullups: anyone pulling wins.
  wire sclBus = ~(sclOe | slaveSclLow);
  wire sdaBus = ~(sdaOe | slaveSdaLow);

  i2c_byte_engine #(.CLOCK_DIV(CLOCK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .command      (command),
    .transmitData (transmitData),
    .transmitAck  (transmitAck),
    .transmitValid(transmitValid),
    .cycleDone    (cycleDone),
    .busy         (busy),
    .receiveData  (receiveData),
    .receiveAck   (receiveAck),
    .sclIn        (sclBus),
    .sdaIn        (sdaBus),
    .sclOe        (sclOe),
    .sdaOe        (sdaOe)
  );

  always #5 clk = ~clk;

  int         checkCount = 0;
  int         errorCount = 0;
  int         doneCount = 0;
  int         startSeen = 0;
  int         stopSeen = 0;
  int         pulseCount = 0;
  int         busyCycles = 0;
  int         sdaGlitch = 0;
  int         highTime[9];
  time        riseTime = 0;
  logic [8:0] capBits = '0;
  logic       byteMode = 1'b0;
  int         d0;
  int         s0;
  int         waitCycles;

  // Bus monitors: command-accept pulses, start/stop conditions, SCL pulse
  // widths, bits seen on SCL rising, and SDA moving while SCL is high.
  always @(negedge clk) if (cycleDone) doneCount++;
  always @(negedge sdaBus) if (sclBus === 1'b1) startSeen++;
  always @(posedge sdaBus) if (sclBus === 1'b1) stopSeen++;
  always @(sdaBus) if (byteMode && sclBus === 1'b1) sdaGlitch++;

  always @(posedge sclBus) begin
    if (byteMode) begin
      capBits  = {capBits[7:0], sdaBus};
      riseTime = $time;
    end
  end

  always @(negedge sclBus) begin
    if (byteMode) begin
      if (pulseCount < 9) highTime[pulseCount] = int'($time - riseTime);
      pulseCount++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one command, wait for cycleDone, then count clk cycles of busy.
  // holdExtra keeps transmitValid up (with a different command) while busy.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] data,
                               input logic ack, input int holdExtra, input string tag);
    int tries = 0;
    @(negedge clk);
    command       = cmd;
    transmitData  = data;
    transmitAck   = ack;
    transmitValid = 1'b1;
    do begin
      @(negedge clk);
      tries++;
    end while (!cycleDone && tries < 50);
    if (!cycleDone) begin
      transmitValid = 1'b0;
      checkOutput({tag, "_accept"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_busyAtAccept"}, busy, 1);
    if (holdExtra > 0) begin
      command      = ~cmd;
      transmitData = ~data;
    end
    busyCycles = 0;
    while (busy && busyCycles < 5000) begin
      busyCycles++;
      if (busyCycles > holdExtra) transmitValid = 1'b0;
      @(negedge clk);
    end
    transmitValid = 1'b0;
    if (busy) checkOutput({tag, "_busyTimeout"}, 32'd0, 32'd1);
  endtask

  // Slave side of one byte: acks a transmit or serves a receive, changing
  // SDA only right after SCL falls; optionally stretches a given bit cell.
  task automatic slaveModel(input logic isRx, input logic slaveAcks,
                            input logic [7:0] slaveByte, input int stretchBit);
    if (isRx) slaveSdaLow = ~slaveByte[7];
    for (int i = 0; i < 8; i++) begin
      @(negedge sclBus);
      if (isRx) slaveSdaLow = (i < 7) ? ~slaveByte[6 - i] : 1'b0;
      else if (i == 7) slaveSdaLow = slaveAcks;
      if (i + 1 == stretchBit) begin
        slaveSclLow = 1'b1;
        repeat (40) @(negedge clk);
        slaveSclLow = 1'b0;
      end
    end
    @(negedge sclBus);
    slaveSdaLow = 1'b0;
  endtask

  task automatic runByte(input logic [1:0] cmd, input logic [7:0] data, input logic ack,
                         input logic slaveAcks, input logic [7:0] slaveByte,
                         input int stretchBit, input int holdExtra, input string tag);
    pulseCount = 0;
    capBits    = '0;
    sdaGlitch  = 0;
    for (int i = 0; i < 9; i++) highTime[i] = 0;
    byteMode = 1'b1;
    fork
      applyStimulus(cmd, data, ack, holdExtra, tag);
      slaveModel(cmd == 2'b11, slaveAcks, slaveByte, stretchBit);
    join
    byteMode = 1'b0;
  endtask

  initial begin
    $display("[TB] starting i2c_byte_engine bench, CLOCK_DIV=%0d", CLOCK_DIV);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cycleDone", cycleDone, 0);
    checkOutput("rst_sclOe", sclOe, 0);
    checkOutput("rst_sdaOe", sdaOe, 0);
    checkOutput("rst_receiveData", receiveData, 8'h00);
    checkOutput("rst_receiveAck", receiveAck, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Start from idle bus.
    d0 = doneCount;
    s0 = startSeen;
    applyStimulus(2'b00, 8'h00, 1'b1, 0, "start");
    checkOutput("start_busyCycles", busyCycles, 12);
    checkOutput("start_donePulses", doneCount - d0, 1);
    checkOutput("start_condition", startSeen - s0, 1);
    checkOutput("start_sclLow", sclBus, 0);
    checkOutput("start_sdaLow", sdaBus, 0);

    // Transmit A0, slave acks.
    runByte(2'b10, 8'hA0, 1'b1, 1'b1, 8'h00, -1, 0, "txA0");
    checkOutput("txA0_pulses", pulseCount, 9);
    checkOutput("txA0_bits", capBits[8:1], 8'hA0);
    checkOutput("txA0_ackBit", capBits[0], 0);
    checkOutput("txA0_sdaStable", sdaGlitch, 0);
    checkOutput("txA0_highTime", highTime[0], 2 * CLOCK_DIV * 10 + 20);
    checkOutput("txA0_receiveAck", receiveAck, 0);
    checkOutput("txA0_receiveDataHeld", receiveData, 8'h00);
    checkOutput("txA0_sclHeldLow", sclBus, 0);

    // Receive 5C, master NACKs.
    runByte(2'b11, 8'h00, 1'b1, 1'b0, 8'h5C, -1, 0, "rx5C");
    checkOutput("rx5C_pulses", pulseCount, 9);
    checkOutput("rx5C_bits", capBits[8:1], 8'h5C);
    checkOutput("rx5C_nackReleased", capBits[0], 1);
    checkOutput("rx5C_receiveData", receiveData, 8'h5C);
    checkOutput("rx5C_receiveAckHeld", receiveAck, 0);

    // Transmit 3C to no slave, with transmitValid held into busy.
    d0 = doneCount;
    runByte(2'b10, 8'h3C, 1'b1, 1'b0, 8'h00, -1, 5, "tx3C");
    checkOutput("tx3C_bits", capBits[8:1], 8'h3C);
    checkOutput("tx3C_receiveAck", receiveAck, 1);
    checkOutput("tx3C_donePulses", doneCount - d0, 1);
    checkOutput("tx3C_receiveDataHeld", receiveData, 8'h5C);

    // Receive A7 with master ACK, slave stretches bit 3 by 40 clk.
    runByte(2'b11, 8'h00, 1'b0, 1'b0, 8'hA7, 3, 0, "rxStretch");
    checkOutput("rxStretch_pulses", pulseCount, 9);
    checkOutput("rxStretch_receiveData", receiveData, 8'hA7);
    checkOutput("rxStretch_masterAck", capBits[0], 0);
    checkOutput("rxStretch_highTime",
                (highTime[3] >= 2 * CLOCK_DIV * 10) && (highTime[3] <= 2 * CLOCK_DIV * 10 + 30), 1);
    checkOutput("rxStretch_sdaStable", sdaGlitch, 0);
    checkOutput("rxStretch_receiveAckHeld", receiveAck, 1);

    // Stop: SCL rises, then SDA rises.
    s0 = stopSeen;
    applyStimulus(2'b01, 8'h00, 1'b1, 0, "stop");
    checkOutput("stop_busyCycles", busyCycles, 14);
    checkOutput("stop_condition", stopSeen - s0, 1);
    checkOutput("stop_sclHigh", sclBus, 1);
    checkOutput("stop_sdaHigh", sdaBus, 1);

    // Reset in the middle of a transmit.
    applyStimulus(2'b00, 8'h00, 1'b1, 0, "start2");
    checkOutput("start2_busyCycles", busyCycles, 12);
    @(negedge clk);
    command       = 2'b10;
    transmitData  = 8'h00;
    transmitValid = 1'b1;
    waitCycles    = 0;
    do begin
      @(negedge clk);
      waitCycles++;
    end while (!cycleDone && waitCycles < 50);
    transmitValid = 1'b0;
    checkOutput("midTx_accept", cycleDone, 1);
    repeat (15) @(negedge clk);
    checkOutput("midTx_busy", busy, 1);
    d0 = doneCount;
    reset = 1'b0;
    #1;
    checkOutput("midTx_rst_sclOe", sclOe, 0);
    checkOutput("midTx_rst_sdaOe", sdaOe, 0);
    checkOutput("midTx_rst_busy", busy, 0);
    checkOutput("midTx_rst_receiveData", receiveData, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midTx_noDone", doneCount - d0, 0);
    checkOutput("midTx_busIdle", {sclBus, sdaBus}, 2'b11);
    applyStimulus(2'b00, 8'h00, 1'b1, 0, "start3");
    checkOutput("start3_busyCycles", busyCycles, 12);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
